rs232_frame_loader: RTL and testbench
=====================================

// Module: rs232_frame_loader
// PURPOSE
// - Parametrised successor of the single-image UART loader.
// - Polls the RS232 UART (Avalon-MM master) and packs BYTES_PER_PIX received bytes into one pixel.
// - Streams NUM_FRAMES consecutive exposures into SRAM, one write strobe per pixel, then signals the HDR wrapper.
// - Sits between the UART IP and the SRAM write port; re-armable by `start`.
// PARAMETERS
// - IMG_W          640  pixels per line
// - IMG_H          480  lines per frame
// - BYTES_PER_PIX  1    bytes per pixel, 1..3; the first byte received lands in pix_data[7:0]
// - NUM_FRAMES     3    exposures per load, 1..8
// - ADDR_W         20   SRAM address width; elaboration error if NUM_FRAMES*IMG_W*IMG_H > 2**ADDR_W
// PORTS
// - avm_clk          in   1                  single clock
// - avm_rst          in   1                  asynchronous reset, active-low
// - avm_address      out  5                  UART register byte offset
// - avm_read         out  1                  Avalon read request
// - avm_write        out  1                  Avalon write request (RS232_ACK_EN only, else tied 0)
// - avm_writedata    out  32                 TX byte in [7:0] (RS232_ACK_EN only, else tied 0)
// - avm_readdata     in   32                 UART read data
// - avm_waitrequest  in   1                  slave stall
// - start            in   1                  1-cycle arm pulse; ignored unless state is IDLE or DONE
// - pix_data         out  8*BYTES_PER_PIX    assembled pixel
// - pix_addr         out  ADDR_W             frame*IMG_W*IMG_H + pixel index
// - pix_frame        out  3                  frame index of pix_data
// - pix_valid        out  1                  1-cycle SRAM write strobe
// - frame_done       out  1                  1-cycle pulse, coincident with the last pixel of each frame
// - all_done         out  1                  level; high in DONE
// - busy             out  1                  high in every state except IDLE and DONE
// BEHAVIOUR
// - Reset values: avm_address=8 (STATUS), avm_read=0, avm_write=0, avm_writedata=0, pix_*=0,
//   pix_valid=0, frame_done=0, all_done=0, busy=0, all counters=0; state IDLE.
// - All outputs are registered.
// - IDLE: on start -> POLL; avm_read=1, avm_address=8.
// - POLL: when ~avm_waitrequest & avm_readdata[7] (RX_OK) -> RDRX, avm_address=0.
//   Otherwise stay in POLL, read held high.
// - RDRX: when ~avm_waitrequest, capture avm_readdata[7:0] into byte slot byte_cnt.
//   - If byte_cnt < BYTES_PER_PIX-1: byte_cnt++.
//   - Else: byte_cnt=0; pix_valid=1 on the next cycle with the full pixel, pix_addr and pix_frame.
//   - Always return to POLL with avm_address=8.
//   - Read latency: last accepted byte -> pix_valid is exactly 1 cycle.
// - Pixel counter wraps at IMG_W*IMG_H-1.
//   - On the wrap, frame_done pulses together with pix_valid and frame_cnt++.
//   - If frame_cnt was NUM_FRAMES-1: -> DONE (or ACK); avm_read=0.
// - pix_addr increments by 1 per pixel, continuous across frames; it never wraps inside a load.
// - DONE: all_done=1, no bus activity. start clears all counters and all_done -> POLL.
// - start while busy: ignored, no counter change.
// - avm_waitrequest held high: outputs frozen, no byte lost or duplicated.
// - Reset mid-load: immediate return to reset values; partial pixel bytes are discarded.
// CONFIGURATION
// - RS232_ACK_EN defined:
//   - After each frame_done -> TXPOLL: read offset 8 until ~avm_waitrequest & readdata[6] (TX_OK).
//   - Then TXWR: avm_write=1, avm_address=4, avm_writedata={24'h0, 8'hA0|frame_idx}, held until ~avm_waitrequest.
//   - Then POLL, or DONE after the last frame.
//   - The host must not send the next frame before the ack arrives.
// - RS232_ACK_EN undefined:
//   - TXPOLL and TXWR states are absent; avm_write and avm_writedata are constant 0.
//   - The frame boundary goes directly to POLL or DONE.
// STRUCTURE
// - Package rs232_pkg holds:
//   - RX_BASE=0, TX_BASE=4, STATUS_BASE=8, TX_OK_BIT=6, RX_OK_BIT=7, ACK_TAG=8'hA0.
//   - typedef enum logic [2:0] {IDLE, POLL, RDRX, TXPOLL, TXWR, DONE} rs232_state_e.
// - Sub-module rs232_byte_packer (params BYTES_PER_PIX):
//   - Inputs: byte_in, byte_vld, clear.
//   - Outputs: pix_out, pix_vld.
//   - Owns byte_cnt and the shift slots.
// TESTING
// - T1 BYTES_PER_PIX=1, NUM_FRAMES=1, IMG 4x2, UART model sends 8'h00..8'h07:
//   8 pix_valid with addr 0..7 and data equal to addr; frame_done on addr 7; all_done=1 afterwards.
// - T2 BYTES_PER_PIX=3, bytes 11,22,33,44,55,66:
//   pix_data=24'h332211 at addr 0, then 24'h665544 at addr 1.
// - T3 NUM_FRAMES=3, IMG 2x2:
//   frame 1 pixels land at addr 4..7 with pix_frame=1; exactly 3 frame_done pulses; last pixel at addr 11.
// - T4 random 0..5-cycle waitrequest stalls on every access plus RX_OK gaps:
//   received stream matches the sent stream byte-for-byte, no duplicates.
// - T5 avm_rst low after 2 of 3 bytes of a pixel, then start:
//   the first pixel written is built only from bytes sent after reset, at addr 0.
// - T6 RS232_ACK_EN, NUM_FRAMES=2:
//   TX writes 8'hA0 then 8'hA1 at offset 4, each only after TX_OK=1;
//   no RX read issued between frame_done and the write completing.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared UART register map, state encoding and ack-byte helper for the RS232 frame loader.
package rs232_pkg;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;
    localparam int         TX_OK_BIT   = 6;
    localparam int         RX_OK_BIT   = 7;
    localparam logic [7:0] ACK_TAG     = 8'hA0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POLL   = 3'd1,
        RDRX   = 3'd2,
        TXPOLL = 3'd3,
        TXWR   = 3'd4,
        DONE   = 3'd5
    } rs232_state_e;

    function automatic logic [7:0] ack_byte(input logic [2:0] frame_idx);
        return ACK_TAG | {5'b0_0000, frame_idx};
    endfunction

endpackage

// File: rtl/rs232_frame_loader_byte_packer.sv
// rs232_byte_packer: collects BYTES_PER_PIX bytes into one pixel, first byte in the low lane.
module rs232_byte_packer #(
    parameter int BYTES_PER_PIX = 1
) (
    input  logic                       avm_clk,
    input  logic                       avm_rst,
    input  logic                       clear,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_vld,
    output logic [8*BYTES_PER_PIX-1:0] pix_out,
    output logic                       pix_vld
);

    localparam int CNT_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BYTES_PER_PIX - 1);

    logic [CNT_W-1:0] byte_cnt_r;
    logic             last_s;

    assign last_s  = (byte_cnt_r == LAST_SLOT);
    assign pix_vld = byte_vld & last_s;

    // byte slot counter, wraps after the final byte of a pixel
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            byte_cnt_r <= '0;
        end else if (clear) begin
            byte_cnt_r <= '0;
        end else if (byte_vld) begin
            byte_cnt_r <= last_s ? '0 : byte_cnt_r + CNT_W'(1);
        end else begin
            byte_cnt_r <= byte_cnt_r;
        end
    end

    // the final byte bypasses the slots so the pixel is complete on the accepting cycle
    if (BYTES_PER_PIX > 1) begin : g_slots
        logic [8*(BYTES_PER_PIX-1)-1:0] slots_r;

        // storage for every byte except the last one of a pixel
        always_ff @(posedge avm_clk or negedge avm_rst) begin
            if (!avm_rst) begin
                slots_r <= '0;
            end else if (clear) begin
                slots_r <= '0;
            end else begin
                for (int i = 0; i < BYTES_PER_PIX - 1; i++) begin
                    if (byte_vld && (byte_cnt_r == CNT_W'(i))) begin
                        slots_r[8*i +: 8] <= byte_in;
                    end else begin
                        slots_r[8*i +: 8] <= slots_r[8*i +: 8];
                    end
                end
            end
        end

        assign pix_out = {byte_in, slots_r};
    end else begin : g_single
        assign pix_out = byte_in;
    end

endmodule

// File: rtl/rs232_frame_loader.sv
// rs232_frame_loader: polls an Avalon-MM RS232 UART and streams NUM_FRAMES images into SRAM.
// Define RS232_ACK_EN to send an ack byte (8'hA0|frame) to the host after every frame.
module rs232_frame_loader
    import rs232_pkg::*;
#(
    parameter int IMG_W         = 640,
    parameter int IMG_H         = 480,
    parameter int BYTES_PER_PIX = 1,
    parameter int NUM_FRAMES    = 3,
    parameter int ADDR_W        = 20
) (
    input  logic                       avm_clk,
    input  logic                       avm_rst,
    output logic [4:0]                 avm_address,
    output logic                       avm_read,
    output logic                       avm_write,
    output logic [31:0]                avm_writedata,
    input  logic [31:0]                avm_readdata,
    input  logic                       avm_waitrequest,
    input  logic                       start,
    output logic [8*BYTES_PER_PIX-1:0] pix_data,
    output logic [ADDR_W-1:0]          pix_addr,
    output logic [2:0]                 pix_frame,
    output logic                       pix_valid,
    output logic                       frame_done,
    output logic                       all_done,
    output logic                       busy
);

    localparam int NPIX     = IMG_W * IMG_H;
    localparam int PIX_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PIX_BITS = 8 * BYTES_PER_PIX;
    localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(NPIX - 1);
    localparam logic [2:0]       LAST_FRAME = 3'(NUM_FRAMES - 1);

    if ((64'(NUM_FRAMES) * 64'(NPIX)) > (64'd1 << ADDR_W)) begin : g_addr_check
        $error("rs232_frame_loader: NUM_FRAMES*IMG_W*IMG_H exceeds 2**ADDR_W");
    end
    if (BYTES_PER_PIX < 1 || BYTES_PER_PIX > 3 || NUM_FRAMES < 1 || NUM_FRAMES > 8) begin : g_range_check
        $error("rs232_frame_loader: BYTES_PER_PIX or NUM_FRAMES out of range");
    end

    rs232_state_e          state_r, state_s;
    logic [4:0]            avm_address_r, avm_address_s;
    logic                  avm_read_r, avm_read_s;
    logic [PIX_BITS-1:0]   pix_data_r, pix_data_s;
    logic [ADDR_W-1:0]     pix_addr_r, pix_addr_s;
    logic [2:0]            pix_frame_r, pix_frame_s;
    logic                  pix_valid_r, pix_valid_s;
    logic                  frame_done_r, frame_done_s;
    logic                  all_done_r, all_done_s;
    logic                  busy_r, busy_s;
    logic [PIX_W-1:0]      pix_cnt_r, pix_cnt_s;
    logic [2:0]            frame_cnt_r, frame_cnt_s;
    logic [ADDR_W-1:0]     addr_cnt_r, addr_cnt_s;
    logic                  clear_s, byte_vld_s, pk_vld_s;
    logic [PIX_BITS-1:0]   pk_pix_s;
    logic                  unused_ok_s;

    assign unused_ok_s = ^avm_readdata[31:8];

`ifdef RS232_ACK_EN
    logic                  avm_write_r, avm_write_s;
    logic [31:0]           avm_writedata_r, avm_writedata_s;
    assign avm_write     = avm_write_r;
    assign avm_writedata = avm_writedata_r;
`else
    assign avm_write     = 1'b0;
    assign avm_writedata = 32'h0000_0000;
`endif

    rs232_byte_packer #(.BYTES_PER_PIX(BYTES_PER_PIX)) u_packer (
        .avm_clk  (avm_clk),
        .avm_rst  (avm_rst),
        .clear    (clear_s),
        .byte_in  (avm_readdata[7:0]),
        .byte_vld (byte_vld_s),
        .pix_out  (pk_pix_s),
        .pix_vld  (pk_vld_s)
    );

    // next-state, counter and output-register logic
    always_comb begin
        state_s       = state_r;
        avm_address_s = avm_address_r;
        avm_read_s    = avm_read_r;
        pix_data_s    = pix_data_r;
        pix_addr_s    = pix_addr_r;
        pix_frame_s   = pix_frame_r;
        pix_valid_s   = 1'b0;
        frame_done_s  = 1'b0;
        pix_cnt_s     = pix_cnt_r;
        frame_cnt_s   = frame_cnt_r;
        addr_cnt_s    = addr_cnt_r;
        clear_s       = 1'b0;
        byte_vld_s    = 1'b0;
`ifdef RS232_ACK_EN
        avm_write_s     = avm_write_r;
        avm_writedata_s = avm_writedata_r;
`endif
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s       = POLL;
                    avm_read_s    = 1'b1;
                    avm_address_s = STATUS_BASE;
                    pix_cnt_s     = '0;
                    frame_cnt_s   = 3'd0;
                    addr_cnt_s    = '0;
                    clear_s       = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            POLL: begin
                if (!avm_waitrequest && avm_readdata[RX_OK_BIT]) begin
                    state_s       = RDRX;
                    avm_address_s = RX_BASE;
                end else begin
                    state_s = POLL;
                end
            end
            RDRX: begin
                if (!avm_waitrequest) begin
                    byte_vld_s    = 1'b1;
                    state_s       = POLL;
                    avm_address_s = STATUS_BASE;
                    if (pk_vld_s) begin
                        pix_valid_s = 1'b1;
                        pix_data_s  = pk_pix_s;
                        pix_addr_s  = addr_cnt_r;
                        pix_frame_s = frame_cnt_r;
                        addr_cnt_s  = addr_cnt_r + ADDR_W'(1);
                        if (pix_cnt_r == LAST_PIX) begin
                            pix_cnt_s    = '0;
                            frame_done_s = 1'b1;
                            frame_cnt_s  = frame_cnt_r + 3'd1;
`ifdef RS232_ACK_EN
                            state_s = TXPOLL;
`else
                            if (frame_cnt_r == LAST_FRAME) begin
                                state_s    = DONE;
                                avm_read_s = 1'b0;
                            end else begin
                                state_s = POLL;
                            end
`endif
                        end else begin
                            pix_cnt_s = pix_cnt_r + PIX_W'(1);
                        end
                    end else begin
                        pix_cnt_s = pix_cnt_r;
                    end
                end else begin
                    state_s = RDRX;
                end
            end
`ifdef RS232_ACK_EN
            TXPOLL: begin
                if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
                    state_s         = TXWR;
                    avm_read_s      = 1'b0;
                    avm_write_s     = 1'b1;
                    avm_address_s   = TX_BASE;
                    avm_writedata_s = {24'h00_0000, ack_byte(pix_frame_r)};
                end else begin
                    state_s = TXPOLL;
                end
            end
            TXWR: begin
                if (!avm_waitrequest) begin
                    avm_write_s     = 1'b0;
                    avm_writedata_s = 32'h0000_0000;
                    avm_address_s   = STATUS_BASE;
                    if (pix_frame_r == LAST_FRAME) begin
                        state_s = DONE;
                    end else begin
                        state_s    = POLL;
                        avm_read_s = 1'b1;
                    end
                end else begin
                    state_s = TXWR;
                end
            end
`endif
            default: begin
                state_s       = IDLE;
                avm_read_s    = 1'b0;
                avm_address_s = STATUS_BASE;
            end
        endcase
        busy_s     = (state_s != IDLE) && (state_s != DONE);
        all_done_s = (state_s == DONE);
    end

    // state and registered outputs
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            state_r       <= IDLE;
            avm_address_r <= STATUS_BASE;
            avm_read_r    <= 1'b0;
            pix_data_r    <= '0;
            pix_addr_r    <= '0;
            pix_frame_r   <= 3'd0;
            pix_valid_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            all_done_r    <= 1'b0;
            busy_r        <= 1'b0;
            pix_cnt_r     <= '0;
            frame_cnt_r   <= 3'd0;
            addr_cnt_r    <= '0;
`ifdef RS232_ACK_EN
            avm_write_r     <= 1'b0;
            avm_writedata_r <= 32'h0000_0000;
`endif
        end else begin
            state_r       <= state_s;
            avm_address_r <= avm_address_s;
            avm_read_r    <= avm_read_s;
            pix_data_r    <= pix_data_s;
            pix_addr_r    <= pix_addr_s;
            pix_frame_r   <= pix_frame_s;
            pix_valid_r   <= pix_valid_s;
            frame_done_r  <= frame_done_s;
            all_done_r    <= all_done_s;
            busy_r        <= busy_s;
            pix_cnt_r     <= pix_cnt_s;
            frame_cnt_r   <= frame_cnt_s;
            addr_cnt_r    <= addr_cnt_s;
`ifdef RS232_ACK_EN
            avm_write_r     <= avm_write_s;
            avm_writedata_r <= avm_writedata_s;
`endif
        end
    end

    assign avm_address = avm_address_r;
    assign avm_read    = avm_read_r;
    assign pix_data    = pix_data_r;
    assign pix_addr    = pix_addr_r;
    assign pix_frame   = pix_frame_r;
    assign pix_valid   = pix_valid_r;
    assign frame_done  = frame_done_r;
    assign all_done    = all_done_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_rs232_frame_loader.sv
// Bench for rs232_frame_loader: two instances (1-byte 3-frame, 3-byte 1-frame) driven by UART models.
module tb_rs232_frame_loader;

    localparam int A_W = 4, A_H = 2, A_BPP = 1, A_NF = 3, A_AW = 5;
    localparam int B_W = 2, B_H = 1, B_BPP = 3, B_NF = 1, B_AW = 2;
    localparam int A_FRAME_BYTES = A_W * A_H * A_BPP;
`ifdef RS232_ACK_EN
    localparam bit ACK_MODE = 1'b1;
`else
    localparam bit ACK_MODE = 1'b0;
`endif

    typedef struct packed {
        logic [23:0] data;
        logic [4:0]  addr;
        logic [2:0]  frame;
        logic        fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic [4:0]  a_address, b_address;
    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_wdata, b_wdata;
    logic [31:0] a_rdata = 32'h0, b_rdata = 32'h0;
    logic        a_wait = 1'b0, b_wait = 1'b0;
    logic        a_start = 1'b0, b_start = 1'b0;
    logic [7:0]  a_pix_data;
    logic [23:0] b_pix_data;
    logic [4:0]  a_pix_addr;
    logic [1:0]  b_pix_addr;
    logic [2:0]  a_pix_frame, b_pix_frame;
    logic        a_pix_valid, a_frame_done, a_all_done, a_busy;
    logic        b_pix_valid, b_frame_done, b_all_done, b_busy;

    rs232_frame_loader #(.IMG_W(A_W), .IMG_H(A_H), .BYTES_PER_PIX(A_BPP), .NUM_FRAMES(A_NF), .ADDR_W(A_AW)) dut_a (
        .avm_clk(clk), .avm_rst(rst_n), .avm_address(a_address), .avm_read(a_read), .avm_write(a_write),
        .avm_writedata(a_wdata), .avm_readdata(a_rdata), .avm_waitrequest(a_wait), .start(a_start),
        .pix_data(a_pix_data), .pix_addr(a_pix_addr), .pix_frame(a_pix_frame), .pix_valid(a_pix_valid),
        .frame_done(a_frame_done), .all_done(a_all_done), .busy(a_busy)
    );

    rs232_frame_loader #(.IMG_W(B_W), .IMG_H(B_H), .BYTES_PER_PIX(B_BPP), .NUM_FRAMES(B_NF), .ADDR_W(B_AW)) dut_b (
        .avm_clk(clk), .avm_rst(rst_n), .avm_address(b_address), .avm_read(b_read), .avm_write(b_write),
        .avm_writedata(b_wdata), .avm_readdata(b_rdata), .avm_waitrequest(b_wait), .start(b_start),
        .pix_data(b_pix_data), .pix_addr(b_pix_addr), .pix_frame(b_pix_frame), .pix_valid(b_pix_valid),
        .frame_done(b_frame_done), .all_done(b_all_done), .busy(b_busy)
    );

    // UART A state: RX byte queue, host pacing (one frame ahead of the last ack), TX acks
    logic [7:0] a_rxq[$];
    logic [7:0] a_acks[$];
    exp_t       exp_a[$];
    int         a_delivered = 0, a_allowed = 0, a_stall_left = 0;
    int         a_bad_rx = 0, a_bad_tx = 0, a_wr_seen = 0;
    bit         a_stall_en = 1'b0, a_gap_en = 1'b0, a_last_tx_ok = 1'b0;
    logic       a_rx_ok, a_tx_ok;

    // UART A model: responses are set up on the falling edge for the next rising edge
    always @(negedge clk) begin
        if (a_stall_left > 0) begin
            a_wait = 1'b1;
            a_stall_left--;
        end else begin
            a_wait = 1'b0;
        end
        a_rx_ok = (a_rxq.size() != 0) && (a_delivered < a_allowed) && (!a_gap_en || $urandom_range(0, 2) != 0);
        a_tx_ok = ACK_MODE && (a_delivered >= a_allowed) && (!a_gap_en || $urandom_range(0, 1) != 0);
        case (a_address)
            5'd8:    a_rdata = {24'h0, a_rx_ok, a_tx_ok, 6'h0};
            5'd0:    a_rdata = {24'h0, (a_rxq.size() != 0) ? a_rxq[0] : 8'hEE};
            default: a_rdata = 32'h0;
        endcase
        if (!a_wait && a_read) begin
            if (a_address == 5'd8) begin
                a_last_tx_ok = a_tx_ok;
            end else if (a_address == 5'd0) begin
                if (a_rxq.size() == 0 || a_delivered >= a_allowed) a_bad_rx++;
                else begin
                    void'(a_rxq.pop_front());
                    a_delivered++;
                end
            end
        end
        if (!a_wait && a_write) begin
            a_wr_seen++;
            if (a_address != 5'd4 || !a_last_tx_ok) a_bad_tx++;
            a_acks.push_back(a_wdata[7:0]);
            a_allowed += A_FRAME_BYTES;
            a_last_tx_ok = 1'b0;
        end
        if (!a_wait && (a_read || a_write) && a_stall_en) a_stall_left = $urandom_range(0, 5);
    end

    logic [7:0] b_rxq[$];
    logic [7:0] b_acks[$];
    exp_t       exp_b[$];

    // UART B model: never stalls, TX always ready
    always @(negedge clk) begin
        b_wait = 1'b0;
        case (b_address)
            5'd8:    b_rdata = {24'h0, b_rxq.size() != 0, 1'b1, 6'h0};
            5'd0:    b_rdata = {24'h0, (b_rxq.size() != 0) ? b_rxq[0] : 8'hEE};
            default: b_rdata = 32'h0;
        endcase
        if (b_read && b_address == 5'd0 && b_rxq.size() != 0) void'(b_rxq.pop_front());
        if (b_write) b_acks.push_back(b_wdata[7:0]);
    end

    task automatic load_a(input bit rnd);
        logic [7:0] v;
        a_delivered = 0;
        a_allowed   = ACK_MODE ? A_FRAME_BYTES : 32'h4000_0000;
        for (int i = 0; i < A_NF * A_W * A_H; i++) begin
            v = rnd ? 8'($urandom) : 8'(i);
            a_rxq.push_back(v);
            exp_a.push_back('{data: {16'h0, v}, addr: 5'(i), frame: 3'(i / (A_W * A_H)),
                              fd: (i % (A_W * A_H)) == (A_W * A_H - 1)});
        end
    endtask

    task automatic pulse_start(input bit on_b);
        @(negedge clk);
        if (on_b) b_start = 1'b1; else a_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        a_start = 1'b0;
    endtask

    task automatic run_a(input int budget, input int poke_at, output int fd_cnt, output int last_addr);
        exp_t e;
        int   n = 0;
        bit   done = 1'b0;
        fd_cnt = 0;
        last_addr = -1;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clk);
            a_start = (n == poke_at) && (cyc % 2 == 0);
            if (a_pix_valid) begin
                checks++;
                if (exp_a.size() == 0) begin
                    failures++;
                    $display("FAIL a_pixel extra pixel addr=%0d data=%h", a_pix_addr, a_pix_data);
                end else begin
                    e = exp_a.pop_front();
                    if ({a_pix_data, a_pix_addr, a_pix_frame, a_frame_done} !== {e.data[7:0], e.addr, e.frame, e.fd}) begin
                        failures++;
                        $display("FAIL a_pixel #%0d got data=%h addr=%0d frame=%0d fd=%b expected data=%h addr=%0d frame=%0d fd=%b",
                                 n, a_pix_data, a_pix_addr, a_pix_frame, a_frame_done, e.data[7:0], e.addr, e.frame, e.fd);
                    end
                end
                n++;
                last_addr = int'(a_pix_addr);
                if (a_frame_done) fd_cnt++;
            end else if (a_frame_done) begin
                checks++;
                failures++;
                $display("FAIL a_frame_done pulse without pix_valid");
            end
            if (exp_a.size() == 0 && a_all_done) done = 1'b1;
        end
        a_start = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL a_timeout got %0d pixels left, required 0 and all_done", exp_a.size());
        end
    endtask

    task automatic run_b(input int budget);
        exp_t e;
        bit   done = 1'b0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clk);
            if (b_pix_valid) begin
                checks++;
                if (exp_b.size() == 0) begin
                    failures++;
                    $display("FAIL b_pixel extra pixel addr=%0d data=%h", b_pix_addr, b_pix_data);
                end else begin
                    e = exp_b.pop_front();
                    if ({b_pix_data, b_pix_addr, b_pix_frame, b_frame_done} !== {e.data, e.addr[1:0], e.frame, e.fd}) begin
                        failures++;
                        $display("FAIL b_pixel got data=%h addr=%0d frame=%0d fd=%b expected data=%h addr=%0d frame=%0d fd=%b",
                                 b_pix_data, b_pix_addr, b_pix_frame, b_frame_done, e.data, e.addr, e.frame, e.fd);
                    end
                end
            end
            if (exp_b.size() == 0 && b_all_done) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL b_timeout got %0d pixels left, required 0 and all_done", exp_b.size());
        end
    endtask

    task automatic check_acks_a();
`ifdef RS232_ACK_EN
        checks++;
        if (a_acks.size() != 3 || a_acks[0] !== 8'hA0 || a_acks[1] !== 8'hA1 || a_acks[2] !== 8'hA2 || a_bad_tx != 0) begin
            failures++;
            $display("FAIL a_acks got count=%0d bad_tx=%0d, required A0 A1 A2 each after TX_OK", a_acks.size(), a_bad_tx);
        end
        a_acks.delete();
`else
        checks++;
        if (a_wr_seen != 0 || a_wdata !== 32'h0) begin
            failures++;
            $display("FAIL a_no_write got writes=%0d wdata=%h, required 0", a_wr_seen, a_wdata);
        end
`endif
        checks++;
        if (a_bad_rx != 0 || a_rxq.size() != 0) begin
            failures++;
            $display("FAIL a_rx_stream got bad_rx=%0d leftover=%0d, required 0 and 0", a_bad_rx, a_rxq.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_address, a_read, a_write, a_wdata} !== {5'd8, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_bus got addr=%0d rd=%b wr=%b wdata=%h, required 8 0 0 0", a_address, a_read, a_write, a_wdata);
        end
        checks++;
        if ({a_pix_data, a_pix_addr, a_pix_frame, a_pix_valid, a_frame_done} !== 19'h0) begin
            failures++;
            $display("FAIL reset_pix got data=%h addr=%0d frame=%0d v=%b fd=%b, required all 0",
                     a_pix_data, a_pix_addr, a_pix_frame, a_pix_valid, a_frame_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_all_done, a_busy, b_all_done, b_busy, b_pix_data, b_pix_valid} !== 29'h0) begin
            failures++;
            $display("FAIL reset_status got a_done=%b a_busy=%b b_done=%b b_busy=%b b_data=%h, required all 0",
                     a_all_done, a_busy, b_all_done, b_busy, b_pix_data);
        end
    endtask

    task automatic test_multi_frame();
        int fd, last;
        load_a(1'b0);
        pulse_start(1'b0);
        checks++;
        if ({a_busy, a_all_done, a_read} !== 3'b101) begin
            failures++;
            $display("FAIL a_armed got busy=%b done=%b read=%b, required 1 0 1", a_busy, a_all_done, a_read);
        end
        run_a(4000, -1, fd, last);
        checks++;
        if (fd != 3 || last != 23) begin
            failures++;
            $display("FAIL a_frames got frame_done=%0d last_addr=%0d, required 3 and 23", fd, last);
        end
        checks++;
        if ({a_all_done, a_busy, a_read} !== 3'b100) begin
            failures++;
            $display("FAIL a_done_state got done=%b busy=%b read=%b, required 1 0 0", a_all_done, a_busy, a_read);
        end
        check_acks_a();
    endtask

    task automatic test_stalls();
        int fd, last;
        a_stall_en = 1'b1;
        a_gap_en   = 1'b1;
        load_a(1'b1);
        pulse_start(1'b0);
        checks++;
        if ({a_all_done, a_busy} !== 2'b01) begin
            failures++;
            $display("FAIL a_rearm got done=%b busy=%b, required 0 1", a_all_done, a_busy);
        end
        run_a(30000, 10, fd, last);
        checks++;
        if (fd != 3 || last != 23) begin
            failures++;
            $display("FAIL a_stall_frames got frame_done=%0d last_addr=%0d, required 3 and 23", fd, last);
        end
        check_acks_a();
        a_stall_en = 1'b0;
        a_gap_en   = 1'b0;
    endtask

    task automatic test_multi_byte();
        logic [7:0] bytes [6];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        foreach (bytes[i]) b_rxq.push_back(bytes[i]);
        exp_b.push_back('{data: 24'h332211, addr: 5'd0, frame: 3'd0, fd: 1'b0});
        exp_b.push_back('{data: 24'h665544, addr: 5'd1, frame: 3'd0, fd: 1'b1});
        pulse_start(1'b1);
        run_b(500);
`ifdef RS232_ACK_EN
        checks++;
        if (b_acks.size() != 1 || b_acks[0] !== 8'hA0) begin
            failures++;
            $display("FAIL b_ack got count=%0d, required one A0", b_acks.size());
        end
        b_acks.delete();
`endif
    endtask

    task automatic test_reset_midload();
        int guard = 0;
        b_rxq.push_back(8'h77);
        b_rxq.push_back(8'h88);
        pulse_start(1'b1);
        while (b_rxq.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (b_busy !== 1'b1 || b_pix_valid !== 1'b0 || guard >= 200) begin
            failures++;
            $display("FAIL b_partial got busy=%b valid=%b guard=%0d, required 1 0 <200", b_busy, b_pix_valid, guard);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({b_busy, b_read, b_address, b_pix_addr, b_pix_data} !== {2'b00, 5'd8, 2'd0, 24'h0}) begin
            failures++;
            $display("FAIL b_midreset got busy=%b rd=%b addr=%0d paddr=%0d data=%h, required 0 0 8 0 0",
                     b_busy, b_read, b_address, b_pix_addr, b_pix_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        b_rxq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        exp_b.push_back('{data: 24'hC3B2A1, addr: 5'd0, frame: 3'd0, fd: 1'b0});
        exp_b.push_back('{data: 24'hF6E5D4, addr: 5'd1, frame: 3'd0, fd: 1'b1});
        pulse_start(1'b1);
        run_b(500);
`ifdef RS232_ACK_EN
        b_acks.delete();
`endif
    endtask

    initial begin
        test_reset();
        test_multi_frame();
        test_stalls();
        test_multi_byte();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
